// File: rtl/fracnet_mul_share_arb.sv
// Round-robin arbiter sharing one 15x5 unsigned multiplier (low 18 product bits) among NUM_REQ requesters.
// Define FRACNET_MUL_ARB_PERF_EN to add the perf_grant_cnt / perf_stall_cnt counters.
module fracnet_mul_share_arb #(
    parameter int NUM_REQ     = 4,
    parameter int ID_W        = 2,
    parameter int MUL_LATENCY = 2
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*15-1:0]   req_a,
    input  logic [NUM_REQ*5-1:0]    req_b,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [17:0]             res_data,
    output logic [ID_W-1:0]         res_id,
    output logic                    idle
`ifdef FRACNET_MUL_ARB_PERF_EN
    ,
    output logic [31:0]             perf_grant_cnt,
    output logic [31:0]             perf_stall_cnt
`endif
);

    logic                w_stall;
    logic                w_found;
    logic                w_accept;
    logic [NUM_REQ-1:0]  w_gnt_oh;
    logic [ID_W-1:0]     w_gnt_id;
    logic [ID_W-1:0]     w_next_ptr;
    logic [14:0]         w_sel_a;
    logic [4:0]          w_sel_b;
    logic [17:0]         w_a18;
    logic [17:0]         w_b18;
    logic [17:0]         w_prod;
    logic                w_tail_busy;

    logic [ID_W-1:0]     r_rr_ptr;
    logic                r_s1_vld;
    logic [14:0]         r_s1_a;
    logic [4:0]          r_s1_b;
    logic [ID_W-1:0]     r_s1_id;

    assign w_stall = res_valid && !res_ready;

    // Two passes give the wrap-around search: first rr_ptr..NUM_REQ-1, then 0..rr_ptr-1.
    always_comb begin
        w_found  = 1'b0;
        w_gnt_oh = '0;
        w_gnt_id = '0;
        w_sel_a  = '0;
        w_sel_b  = '0;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (!w_found && (j >= 32'(r_rr_ptr)) && req_valid[j]) begin
                w_found     = 1'b1;
                w_gnt_oh[j] = 1'b1;
                w_gnt_id    = ID_W'(j);
                w_sel_a     = req_a[j*15 +: 15];
                w_sel_b     = req_b[j*5 +: 5];
            end
        end
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (!w_found && (j < 32'(r_rr_ptr)) && req_valid[j]) begin
                w_found     = 1'b1;
                w_gnt_oh[j] = 1'b1;
                w_gnt_id    = ID_W'(j);
                w_sel_a     = req_a[j*15 +: 15];
                w_sel_b     = req_b[j*5 +: 5];
            end
        end
    end

    assign w_accept   = w_found && !w_stall && ap_rst_n;
    assign req_ready  = w_accept ? w_gnt_oh : '0;
    assign w_next_ptr = (w_gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt_id + ID_W'(1);

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_rr_ptr <= '0;
            r_s1_vld <= 1'b0;
            r_s1_a   <= '0;
            r_s1_b   <= '0;
            r_s1_id  <= '0;
        end else if (!w_stall) begin
            r_s1_vld <= w_accept;
            if (w_accept) begin
                r_rr_ptr <= w_next_ptr;
                r_s1_a   <= w_sel_a;
                r_s1_b   <= w_sel_b;
                r_s1_id  <= w_gnt_id;
            end
        end
    end

    // Operands widened to 18 bits so the product is taken modulo 2^18 directly.
    assign w_a18  = {3'b000, r_s1_a};
    assign w_b18  = {13'd0, r_s1_b};
    assign w_prod = w_a18 * w_b18;

    generate
        if (MUL_LATENCY == 1) begin : g_lat1
            assign res_valid   = r_s1_vld;
            assign res_data    = w_prod;
            assign res_id      = r_s1_id;
            assign w_tail_busy = 1'b0;
        end else begin : g_latn
            logic [MUL_LATENCY-2:0] r_pv;
            logic [17:0]            r_p   [MUL_LATENCY-1];
            logic [ID_W-1:0]        r_pid [MUL_LATENCY-1];

            always_ff @(posedge ap_clk or negedge ap_rst_n) begin
                if (!ap_rst_n) begin
                    r_pv <= '0;
                    for (int unsigned k = 0; k < MUL_LATENCY - 1; k++) begin
                        r_p[k]   <= '0;
                        r_pid[k] <= '0;
                    end
                end else if (!w_stall) begin
                    r_pv[0]  <= r_s1_vld;
                    r_p[0]   <= w_prod;
                    r_pid[0] <= r_s1_id;
                    for (int unsigned k = 1; k < MUL_LATENCY - 1; k++) begin
                        r_pv[k]  <= r_pv[k-1];
                        r_p[k]   <= r_p[k-1];
                        r_pid[k] <= r_pid[k-1];
                    end
                end
            end

            assign res_valid   = r_pv[MUL_LATENCY-2];
            assign res_data    = r_p[MUL_LATENCY-2];
            assign res_id      = r_pid[MUL_LATENCY-2];
            assign w_tail_busy = |r_pv;
        end
    endgenerate

    assign idle = !(r_s1_vld || w_tail_busy);

`ifdef FRACNET_MUL_ARB_PERF_EN
    logic [31:0] r_grant_cnt;
    logic [31:0] r_stall_cnt;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_grant_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_accept) r_grant_cnt <= r_grant_cnt + 32'd1;
            if (w_stall)  r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign perf_grant_cnt = r_grant_cnt;
    assign perf_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_fracnet_mul_share_arb.sv
// Directed + randomized bench for fracnet_mul_share_arb; reference model is a FIFO of in-flight products with ages.
module tb_fracnet_mul_share_arb;

    localparam int N   = 4;
    localparam int IDW = 2;
    localparam int L   = 2;

    logic              ap_clk = 1'b0;
    logic              ap_rst_n = 1'b0;
    logic [N-1:0]      req_valid = '0;
    logic [N-1:0]      req_ready;
    logic [N*15-1:0]   req_a = '0;
    logic [N*5-1:0]    req_b = '0;
    logic              res_valid;
    logic              res_ready = 1'b0;
    logic [17:0]       res_data;
    logic [IDW-1:0]    res_id;
    logic              idle;
`ifdef FRACNET_MUL_ARB_PERF_EN
    logic [31:0]       perf_grant_cnt;
    logic [31:0]       perf_stall_cnt;
`endif

    always #5 ap_clk = ~ap_clk;

    fracnet_mul_share_arb #(
        .NUM_REQ     (N),
        .ID_W        (IDW),
        .MUL_LATENCY (L)
    ) dut (
        .ap_clk    (ap_clk),
        .ap_rst_n  (ap_rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_id    (res_id),
        .idle      (idle)
`ifdef FRACNET_MUL_ARB_PERF_EN
        ,
        .perf_grant_cnt (perf_grant_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    typedef struct {
        int id;
        int prod;
        int age;
    } ent_t;

    ent_t q[$];
    int   m_ptr;
    int   m_grants;
    int   m_stalls;
    int   a_v [N];
    int   b_v [N];
    int   n_chk;
    int   n_pass;
    int   n_fail;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, check against the model, advance the model at the edge.
    task automatic step(input logic [N-1:0] v, input logic rr);
        bit           ov;
        bit           stall;
        int           g;
        logic [N-1:0] exp_rdy;
        req_valid = v;
        res_ready = rr;
        for (int i = 0; i < N; i++) begin
            req_a[i*15 +: 15] = 15'(a_v[i]);
            req_b[i*5 +: 5]   = 5'(b_v[i]);
        end
        #1;
        ov    = (q.size() > 0) && (q[0].age == L - 1);
        stall = ov && !rr;
        g     = -1;
        if (!stall) begin
            for (int k = 0; k < N; k++) begin
                int j;
                j = (m_ptr + k) % N;
                if (g < 0 && v[j]) g = j;
            end
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        chk("res_valid", 32'(res_valid), 32'(ov));
        chk("idle", 32'(idle), 32'(q.size() == 0));
        if (ov) begin
            chk("res_data", 32'(res_data), q[0].prod);
            chk("res_id", 32'(res_id), q[0].id);
        end
`ifdef FRACNET_MUL_ARB_PERF_EN
        chk("perf_grant_cnt", perf_grant_cnt, m_grants);
        chk("perf_stall_cnt", perf_stall_cnt, m_stalls);
`endif
        @(posedge ap_clk);
        if (stall) begin
            m_stalls++;
        end else begin
            if (ov) void'(q.pop_front());
            foreach (q[i]) q[i].age++;
            if (g >= 0) begin
                q.push_back('{g, (a_v[g] * b_v[g]) % 262144, 0});
                m_ptr = (g + 1) % N;
                m_grants++;
            end
        end
        @(negedge ap_clk);
    endtask

    task automatic model_reset();
        q.delete();
        m_ptr    = 0;
        m_grants = 0;
        m_stalls = 0;
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        n_fail = 0;
        model_reset();
        for (int i = 0; i < N; i++) begin
            a_v[i] = 0;
            b_v[i] = 0;
        end

        // Reset state, with requests already asserted.
        req_valid = '1;
        @(negedge ap_clk);
        @(negedge ap_clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_res_valid", 32'(res_valid), 0);
        chk("rst_res_data", 32'(res_data), 0);
        chk("rst_res_id", 32'(res_id), 0);
        chk("rst_idle", 32'(idle), 1);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        step('0, 1'b1);

        // Single request, 100*7.
        a_v[0] = 100;
        b_v[0] = 7;
        step(4'b0001, 1'b1);
        step(4'b0000, 1'b1);
        chk("single_data", 32'(res_data), 700);
        chk("single_id", 32'(res_id), 0);
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b1);

        // Truncation to 18 bits, requester 1.
        a_v[1] = 32767;
        b_v[1] = 31;
        step(4'b0010, 1'b1);
        step(4'b0000, 1'b1);
        chk("trunc_data", 32'(res_data), 229345);
        step(4'b0000, 1'b1);

        // Round robin with all requesters valid; pointer wraps several times.
        for (int i = 0; i < N; i++) begin
            a_v[i] = i + 1;
            b_v[i] = 2;
        end
        for (int c = 0; c < 10; c++) step(4'b1111, 1'b1);

        // Backpressure for 3 cycles mid-stream, then resume.
        for (int c = 0; c < 3; c++) step(4'b1111, 1'b0);
        for (int c = 0; c < 6; c++) step(4'b1111, 1'b1);

        // Skip and hold: requester 2 alone sets the pointer to 3, then 2 again wraps past 3,0,1.
        step(4'b0100, 1'b1);
        step(4'b0100, 1'b1);
        for (int c = 0; c < 5; c++) step(4'b0000, 1'b1);
        step(4'b1001, 1'b1);
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b1);

        // Randomized traffic and backpressure.
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < N; i++) begin
                a_v[i] = int'($urandom_range(0, 32767));
                b_v[i] = int'($urandom_range(0, 31));
            end
            step(4'($urandom_range(0, 15)), $urandom_range(0, 3) != 0);
        end
        for (int c = 0; c < 6; c++) step(4'b0000, 1'b1);

        // Reset with two products in flight.
        step(4'b1111, 1'b1);
        step(4'b1111, 1'b1);
        #2;
        ap_rst_n = 1'b0;
        #1;
        chk("midrst_res_valid", 32'(res_valid), 0);
        chk("midrst_idle", 32'(idle), 1);
        chk("midrst_req_ready", 32'(req_ready), 0);
        chk("midrst_res_data", 32'(res_data), 0);
`ifdef FRACNET_MUL_ARB_PERF_EN
        chk("midrst_perf_grant", perf_grant_cnt, 0);
        chk("midrst_perf_stall", perf_stall_cnt, 0);
`endif
        model_reset();
        @(negedge ap_clk);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        for (int c = 0; c < 4; c++) step(4'b0000, 1'b1);
        step(4'b1111, 1'b1);
        for (int c = 0; c < 3; c++) step(4'b0000, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
